// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared UART definitions: bit-timing constants and the receiver state encoding,
// used by both the receiver and the transmitter.
package uart_pkg;

    localparam int CLK_DIV    = 41;   // 12.5 MHz / (19200 x 16)
    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;

    localparam int TICK_W = $clog2(OVERSAMPLE);

    // Tick-count values that mark the middle of the start bit and the end of a full bit.
    localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/baud_tick_gen.sv
`timescale 1ns/1ps
// Free-running divider producing a one-cycle tick every DIV clocks;
// shared by the UART receiver and transmitter.
module baud_tick_gen #(
    parameter int DIV = uart_pkg::CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (count == CNT_LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick = (count == CNT_LAST);

endmodule

// File: rtl/uart_byte_receiver.sv
`timescale 1ns/1ps
// 16x oversampling UART receiver: 2-flop synchronizer, framing FSM and shift register,
// reporting each good byte with rx_done and each low stop bit with frame_error.
module uart_byte_receiver
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = uart_pkg::CLK_DIV,
    parameter int DATA_BITS = uart_pkg::DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 frame_error,
    output logic                 busy
);

    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic                 tick;
    logic                 rx_meta;
    logic                 rx_s;

    rx_state_t            state,      state_next;
    logic [TICK_W-1:0]    tick_cnt,   tick_next;
    logic [BIT_W-1:0]     bit_cnt,    bit_next;
    logic [DATA_BITS-1:0] shift_reg,  shift_next;
    logic                 done_next;
    logic                 err_next;

    baud_tick_gen #(
        .DIV (CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Synchronizer resets to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        tick_next  = tick_cnt;
        bit_next   = bit_cnt;
        shift_next = shift_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;

        if (tick) begin
            case (state)
                RX_IDLE: begin
                    if (!rx_s) begin
                        state_next = RX_START;
                        tick_next  = '0;
                    end
                end

                RX_START: begin
                    if (tick_cnt == MID_TICK) begin
                        if (!rx_s) begin
                            state_next = RX_DATA;
                            tick_next  = '0;
                            bit_next   = '0;
                        end else begin
                            state_next = RX_IDLE;
                        end
                    end else begin
                        tick_next = tick_cnt + TICK_W'(1);
                    end
                end

                RX_DATA: begin
                    if (tick_cnt == LAST_TICK) begin
                        tick_next  = '0;
                        shift_next = {rx_s, shift_reg[DATA_BITS-1:1]};
                        if (bit_cnt == BIT_LAST) begin
                            state_next = RX_STOP;
                            bit_next   = '0;
                        end else begin
                            bit_next = bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        tick_next = tick_cnt + TICK_W'(1);
                    end
                end

                RX_STOP: begin
                    if (tick_cnt == LAST_TICK) begin
                        tick_next = '0;
                        if (rx_s) begin
                            done_next  = 1'b1;
                            state_next = RX_IDLE;
                        end else begin
                            err_next   = 1'b1;
                            state_next = RX_WAIT_HIGH;
                        end
                    end else begin
                        tick_next = tick_cnt + TICK_W'(1);
                    end
                end

                // A held-low break stays here, so it reports only one frame_error.
                RX_WAIT_HIGH: begin
                    if (rx_s) begin
                        state_next = RX_IDLE;
                    end
                end

                default: begin
                    state_next = RX_IDLE;
                end
            endcase
        end
    end

    // NOTE: the shift register is an ordinary datapath register, so it is reset like the FSM state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RX_IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            rx_data     <= '0;
            rx_done     <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_next;
            tick_cnt    <= tick_next;
            bit_cnt     <= bit_next;
            shift_reg   <= shift_next;
            rx_done     <= done_next;
            frame_error <= err_next;
            // rx_data and rx_done change on the same edge, so the byte is valid while rx_done is high.
            if (done_next) begin
                rx_data <= shift_reg;
            end
        end
    end

    assign busy = (state != RX_IDLE);

endmodule

// File: tb/tb_uart_byte_receiver.sv
`timescale 1ns/1ps
// Self-checking bench for uart_byte_receiver: drives serial frames in real time and
// checks every output pulse and every rx_data change against a frame-level model.
module tb_uart_byte_receiver;

    localparam int CLK_NS = 80;      // 12.5 MHz
    localparam int BIT_NS = 52083;   // 19200 baud
    localparam int BIT_CYC = BIT_NS / CLK_NS;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } expect_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_error;
    logic       busy;

    int         total = 0;
    int         bad = 0;

    // Frame-level model: expected pulse sequence and the byte rx_data must show.
    expect_t    exp_q[$];
    expect_t    pop_e;
    logic [7:0] model_data = 8'h00;

    logic       rst_seen = 1'b1;
    logic       prev_done = 1'b0;
    logic       prev_err = 1'b0;
    logic [7:0] prev_data = 8'h00;
    longint     cyc = 0;
    longint     last_done_cyc = 0;
    longint     prev_done_cyc = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;

    uart_byte_receiver #(
        .CLK_DIV   (41),
        .DATA_BITS (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .frame_error (frame_error),
        .busy        (busy)
    );

    always #(CLK_NS / 2) clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one frame LSB-first and record what the receiver must report for it.
    task automatic send_frame(input logic [7:0] data, input bit stop_high, input int bit_ns);
        expect_t e;
        e.is_err = !stop_high;
        e.data   = data;
        exp_q.push_back(e);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            #(bit_ns);
        end
        rx = stop_high;
        #(bit_ns);
    endtask

    always @(posedge clk) begin
        rst_seen <= reset;
        cyc      <= cyc + 1;
    end

    // Compare process: runs on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (rst_seen) begin
            check("reset_outputs", {21'd0, rx_data, rx_done, frame_error, busy}, 32'd0);
            model_data = 8'h00;
        end else begin
            if (rx_done || frame_error) begin
                check("pulse_exclusive", rx_done & frame_error, 0);
                check("pulse_single_cycle", (rx_done & prev_done) | (frame_error & prev_err), 0);
                if (!(rx_done && prev_done) && !(frame_error && prev_err)) begin
                    check("pulse_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        pop_e = exp_q.pop_front();
                        check("pulse_kind", frame_error, pop_e.is_err);
                        if (!pop_e.is_err) model_data = pop_e.data;
                    end
                    if (rx_done) begin
                        done_cnt++;
                        prev_done_cyc = last_done_cyc;
                        last_done_cyc = cyc;
                    end
                    if (frame_error) err_cnt++;
                end
            end
            if (rx_done || (rx_data !== prev_data)) begin
                check("rx_data_vs_model", rx_data, model_data);
            end
        end
        prev_done = rx_done;
        prev_err  = frame_error;
        prev_data = rx_data;
    end

    initial begin
        #(30_000_000);
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int d0;
        int e0;
        int wait_cyc;
        logic [7:0] rnd;
        int rnd_bit;

        reset = 1'b1;
        rx    = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_rx_data", rx_data, 8'h00);
        reset = 1'b0;
        #(BIT_NS);

        // Data bits on the line 1,1,0,0,0,1,1,0 (LSB first) form 8'h63.
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'b0110_0011, 1'b1, BIT_NS);
        #(BIT_NS);
        check("f63_done_count", done_cnt - d0, 1);
        check("f63_no_error", err_cnt - e0, 0);
        check("f63_rx_data", rx_data, 8'h63);

        // Short low glitch on an idle line.
        d0 = done_cnt; e0 = err_cnt;
        rx = 1'b0;
        #(2000);
        rx = 1'b1;
        #(BIT_NS);
        check("glitch_busy_cleared", busy, 0);
        check("glitch_no_pulses", (done_cnt - d0) + (err_cnt - e0), 0);

        // Framing error followed by a held-low break.
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'hA5, 1'b0, BIT_NS);
        #(5 * BIT_NS);
        check("break_busy_held", busy, 1);
        check("break_one_error", err_cnt - e0, 1);
        check("break_no_done", done_cnt - d0, 0);
        check("break_rx_data_kept", rx_data, 8'h63);
        rx = 1'b1;
        wait_cyc = 0;
        while (busy && wait_cyc < 200) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("break_release_idle", busy, 0);
        #(BIT_NS);
        check("break_one_error_after", err_cnt - e0, 1);

        // Back-to-back frames with a single stop bit.
        d0 = done_cnt;
        send_frame(8'h00, 1'b1, BIT_NS);
        check("b2b_first_data", rx_data, 8'h00);
        send_frame(8'hFF, 1'b1, BIT_NS);
        #(BIT_NS);
        check("b2b_done_count", done_cnt - d0, 2);
        check("b2b_second_data", rx_data, 8'hFF);
        check("b2b_spacing", (last_done_cyc - prev_done_cyc > 10 * BIT_CYC - 100) &&
                             (last_done_cyc - prev_done_cyc < 10 * BIT_CYC + 100), 1);

        // Reset pulsed during data bit 4, then a clean frame.
        d0 = done_cnt; e0 = err_cnt;
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b0;
            #(BIT_NS);
        end
        rx = 1'b1;
        #(BIT_NS / 2);
        reset = 1'b1;
        #(10 * CLK_NS);
        reset = 1'b0;
        #(BIT_NS / 2);
        rx = 1'b1;
        #(2 * BIT_NS);
        check("abort_no_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
        check("abort_rx_data_cleared", rx_data, 8'h00);
        send_frame(8'h3C, 1'b1, BIT_NS);
        #(BIT_NS);
        check("after_abort_done", done_cnt - d0, 1);
        check("after_abort_data", rx_data, 8'h3C);

        // Baud mismatch of +2% and -2%.
        d0 = done_cnt;
        send_frame(8'h55, 1'b1, (BIT_NS * 102) / 100);
        #(BIT_NS);
        check("slow_baud_data", rx_data, 8'h55);
        send_frame(8'h55, 1'b1, (BIT_NS * 98) / 100);
        #(BIT_NS);
        check("fast_baud_data", rx_data, 8'h55);
        check("baud_done_count", done_cnt - d0, 2);

        // Random bytes at randomly perturbed baud rates.
        for (int n = 0; n < 2; n++) begin
            d0      = done_cnt;
            rnd     = 8'($urandom_range(0, 255));
            rnd_bit = BIT_NS - 750 + int'($urandom_range(0, 1500));
            send_frame(rnd, 1'b1, rnd_bit);
            #(BIT_NS / 2 + int'($urandom_range(0, BIT_NS / 2)));
            check("rand_done", done_cnt - d0, 1);
            check("rand_data", rx_data, rnd);
        end

        #(BIT_NS);
        check("queue_drained", exp_q.size(), 0);
        check("final_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_byte_receiver.md
UART_BYTE_RECEIVER -- requirements
Module: uart_byte_receiver

Interface
REQ-001 SHALL have parameter CLK_DIV, default 41: system clocks per 16x oversample tick (12.5 MHz / (19200 x 16)).
REQ-002 SHALL have parameter DATA_BITS, default 8: data bits per frame.
REQ-003 SHALL have port clk, input, 1 bit: single system clock, 12.5 MHz; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-006 SHALL have port rx_data, output, DATA_BITS bits: last correctly framed byte.
REQ-007 SHALL have port rx_done, output, 1 bit: one-cycle pulse when rx_data is updated.
REQ-008 SHALL have port frame_error, output, 1 bit: one-cycle pulse when the stop bit is sampled low.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer; all sampling uses the synchronized value (rx_s), which is 2 cycles behind rx.
REQ-011 SHALL generate tick for one cycle every CLK_DIV clocks from a free-running counter 0..CLK_DIV-1 that wraps to 0.
REQ-012 SHALL implement states IDLE, START, DATA, STOP and WAIT_HIGH; all state, tick-count and bit-count changes occur only on tick cycles.
REQ-013 IDLE: on a tick with rx_s=0, go to START and clear the 4-bit tick count.
REQ-014 START: on tick count 7 (mid start bit), go to DATA if rx_s=0 with tick and bit counts cleared; otherwise return to IDLE as a glitch, with no output pulse.
REQ-015 DATA: on every 16th tick, shift rx_s into the shift register LSB-first and increment the bit count; after DATA_BITS bits, go to STOP.
REQ-016 STOP: on the 16th tick, if rx_s=1, load rx_data from the shift register, pulse rx_done in the next cycle and go to IDLE.
REQ-017 STOP: on the 16th tick, if rx_s=0, pulse frame_error in the next cycle, leave rx_data unchanged and go to WAIT_HIGH.
REQ-018 WAIT_HIGH: go to IDLE on the first tick with rx_s=1, so a held-low break line produces exactly one frame_error.
REQ-019 rx_done and frame_error SHALL never be high in the same cycle, and neither SHALL be high for more than one cycle.
REQ-020 rx_data SHALL hold its value between rx_done pulses.
REQ-021 A start edge arriving in the same cycle that rx_done is pulsed SHALL be detected on the next tick without loss, giving back-to-back frames with a single stop bit.
REQ-022 Baud mismatch up to +/-2% SHALL still sample every bit within its centre half.

Reset
REQ-023 When reset=1 at a clock edge: state=IDLE; divider, tick count, bit count and shift register cleared; synchronizer flops set to 1.
REQ-024 During reset: rx_data=0, rx_done=0, frame_error=0, busy=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no pulse; the next start bit after release SHALL be received normally.

Structure
REQ-026 Shared package uart_pkg SHALL hold CLK_DIV, OVERSAMPLE=16, DATA_BITS and the receiver state encoding; the transmitter SHALL reuse it.
REQ-027 SHALL instantiate one sub-module, baud_tick_gen (counter and tick), shared with the transmitter; the FSM, synchronizer and shift register SHALL stay in uart_byte_receiver.
REQ-028 SHALL contain no latches and no logic clocked by anything other than clk.

Verification
REQ-029 Idle then a frame at 52083 ns/bit, start bit then data bits 1,1,0,0,0,1,1,0, then stop bit -> exactly one rx_done; rx_data=8'h63; frame_error never high.
REQ-030 A 2 us low glitch on idle rx -> no rx_done, no frame_error; busy returns to 0 within 1 bit time.
REQ-031 Frame 8'hA5 with stop bit driven low, then rx held low for 5 bit times -> exactly one frame_error pulse; rx_data keeps its previous value; busy stays high until rx returns high.
REQ-032 Back-to-back frames 8'h00 then 8'hFF, one stop bit each -> two rx_done pulses ~10 bit times apart; rx_data=8'h00, then 8'hFF.
REQ-033 reset pulsed during data bit 4 of a frame, then a clean 8'h3C frame -> no pulse for the aborted frame; rx_done with rx_data=8'h3C.
REQ-034 Bit period scaled +2% and -2% with 8'h55 -> rx_data=8'h55 in both cases.
